// File: rtl/game_round_ctrl.sv
// Two-player quiz round controller.
// Sequences questions from an external generator, arbitrates buzzer edges
// with a round-robin tie-break, judges answers, keeps saturating scores and
// ends the game on a winning score or after the last question.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | after reset; waits for start
// LOAD  | one cycle; q_load pulse asks the generator for question q_index
// WAIT  | question live; first buzzer edge wins, or the timeout expires
// JUDGE | one cycle; latched answer compared with q_ans, score updated
// SHOW  | verdict held for SHOW_CYC cycles
// DONE  | game finished; scores and winner held until the next start
module game_round_ctrl #(
    parameter int NUM_Q       = 8,
    parameter int WIN_SCORE   = 5,
    parameter int TIMEOUT_CYC = 1000,
    parameter int SHOW_CYC    = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       p1_req,
    input  logic       p2_req,
    input  logic       p1_ans,
    input  logic       p2_ans,
    input  logic       q_ans,
    output logic [2:0] q_index,
    output logic       q_load,
    output logic       q_valid,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [1:0] buzzed,
    output logic       verdict,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int TMO_W  = $clog2(TIMEOUT_CYC);
    localparam int SHOW_W = $clog2(SHOW_CYC + 1);

    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [SHOW_W-1:0] SHOW_LOAD = SHOW_W'(SHOW_CYC - 1);
    localparam logic [2:0]        LAST_Q    = 3'(NUM_Q - 1);
    localparam logic [3:0]        WIN       = 4'(WIN_SCORE);

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_P1   = 2'b01;
    localparam logic [1:0] SEL_P2   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_JUDGE,
        S_SHOW,
        S_DONE
    } state_t;

    state_t             state;
    logic               p1_prev;
    logic               p2_prev;
    logic               p1_edge;
    logic               p2_edge;
    logic               pick_p1;
    logic               pick_p2;
    logic               tie;
    logic               prio_p2;
    logic               ans_lat;
    logic               judge_ok;
    logic               game_end;
    logic [1:0]         winner_next;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [SHOW_W-1:0]  show_cnt;

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == 4'd15) ? s : s + 4'd1;
    endfunction

    assign p1_edge  = p1_req & ~p1_prev;
    assign p2_edge  = p2_req & ~p2_prev;
    assign judge_ok = (ans_lat == q_ans);
    assign game_end = (score_p1 >= WIN) || (score_p2 >= WIN) || (q_index == LAST_Q);

    // Buzzer history, registered every cycle regardless of state so that a
    // level held across rounds never looks like a fresh press.
    always_ff @(posedge clk) begin
        if (reset) begin
            p1_prev <= 1'b0;
            p2_prev <= 1'b0;
        end else begin
            p1_prev <= p1_req;
            p2_prev <= p2_req;
        end
    end

    // Buzzer arbitration: a lone edge wins outright, a tie goes to whoever
    // the round-robin bit currently favours.
    always_comb begin
        pick_p1 = 1'b0;
        pick_p2 = 1'b0;
        tie     = 1'b0;
        if (p1_edge && p2_edge) begin
            tie = 1'b1;
            if (prio_p2) begin
                pick_p2 = 1'b1;
            end else begin
                pick_p1 = 1'b1;
            end
        end else if (p1_edge) begin
            pick_p1 = 1'b1;
        end else if (p2_edge) begin
            pick_p2 = 1'b1;
        end
    end

    // Final-score comparison used when the game closes.
    always_comb begin
        winner_next = SEL_NONE;
        if (score_p1 > score_p2) begin
            winner_next = SEL_P1;
        end else if (score_p2 > score_p1) begin
            winner_next = SEL_P2;
        end
    end

    // Round sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            q_index   <= 3'd0;
            q_load    <= 1'b0;
            q_valid   <= 1'b0;
            score_p1  <= 4'd0;
            score_p2  <= 4'd0;
            buzzed    <= SEL_NONE;
            verdict   <= 1'b0;
            game_over <= 1'b0;
            winner    <= SEL_NONE;
            tmo_cnt   <= '0;
            show_cnt  <= '0;
            ans_lat   <= 1'b0;
            prio_p2   <= 1'b0;
        end else begin
            q_load <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LOAD;
                        q_load   <= 1'b1;
                        q_index  <= 3'd0;
                        score_p1 <= 4'd0;
                        score_p2 <= 4'd0;
                        buzzed   <= SEL_NONE;
                    end
                end

                S_LOAD: begin
                    state   <= S_WAIT;
                    q_valid <= 1'b1;
                    buzzed  <= SEL_NONE;
                    tmo_cnt <= '0;
                end

                S_WAIT: begin
                    // An edge in the expiry cycle still wins over the timeout.
                    if (pick_p1 || pick_p2) begin
                        state   <= S_JUDGE;
                        buzzed  <= pick_p1 ? SEL_P1 : SEL_P2;
                        ans_lat <= pick_p1 ? p1_ans : p2_ans;
                        if (tie) begin
                            prio_p2 <= ~prio_p2;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state    <= S_SHOW;
                        q_valid  <= 1'b0;
                        buzzed   <= SEL_NONE;
                        verdict  <= 1'b0;
                        show_cnt <= SHOW_LOAD;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                S_JUDGE: begin
                    state    <= S_SHOW;
                    q_valid  <= 1'b0;
                    verdict  <= judge_ok;
                    show_cnt <= SHOW_LOAD;
                    // A wrong answer hands the point to the opponent.
                    if ((buzzed == SEL_P1) == judge_ok) begin
                        score_p1 <= sat_inc(score_p1);
                    end else begin
                        score_p2 <= sat_inc(score_p2);
                    end
                end

                S_SHOW: begin
                    if (show_cnt == '0) begin
                        if (game_end) begin
                            state     <= S_DONE;
                            game_over <= 1'b1;
                            winner    <= winner_next;
                        end else begin
                            state   <= S_LOAD;
                            q_load  <= 1'b1;
                            q_index <= q_index + 3'd1;
                            buzzed  <= SEL_NONE;
                        end
                    end else begin
                        show_cnt <= show_cnt - SHOW_W'(1);
                    end
                end

                S_DONE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        q_load    <= 1'b1;
                        q_index   <= 3'd0;
                        score_p1  <= 4'd0;
                        score_p2  <= 4'd0;
                        buzzed    <= SEL_NONE;
                        game_over <= 1'b0;
                        winner    <= SEL_NONE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: a table of question rounds driven in a loop, a
// scoreboard of expected verdict/score snapshots checked on every entry to
// the verdict display, and hand-written sequences for the multi-cycle cases.
module tb_game_round_ctrl;

    localparam int NUM_Q       = 8;
    localparam int WIN_SCORE   = 5;
    localparam int TIMEOUT_CYC = 20;
    localparam int SHOW_CYC    = 4;
    localparam int BUDGET      = 200;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       p1_req;
    logic       p2_req;
    logic       p1_ans;
    logic       p2_ans;
    logic       q_ans;
    logic [2:0] q_index;
    logic       q_load;
    logic       q_valid;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic [1:0] buzzed;
    logic       verdict;
    logic       game_over;
    logic [1:0] winner;

    game_round_ctrl #(
        .NUM_Q       (NUM_Q),
        .WIN_SCORE   (WIN_SCORE),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .SHOW_CYC    (SHOW_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .p1_req    (p1_req),
        .p2_req    (p2_req),
        .p1_ans    (p1_ans),
        .p2_ans    (p2_ans),
        .q_ans     (q_ans),
        .q_index   (q_index),
        .q_load    (q_load),
        .q_valid   (q_valid),
        .score_p1  (score_p1),
        .score_p2  (score_p2),
        .buzzed    (buzzed),
        .verdict   (verdict),
        .game_over (game_over),
        .winner    (winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start_game;
        logic       hold;
        logic       p1;
        logic       p2;
        logic       p1a;
        logic       p2a;
        logic       qa;
        int         dly;
        logic [1:0] exp_buzzed;
        logic       exp_verdict;
    } round_t;

    typedef struct {
        logic [1:0] buzzed;
        logic       verdict;
        logic [3:0] s1;
        logic [3:0] s2;
    } show_t;

    round_t     tbl[$];
    show_t      sb_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [3:0] m_s1 = 4'd0;
    logic [3:0] m_s2 = 4'd0;
    int         m_q  = 0;
    logic       prev_qv = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] sat(input logic [3:0] s);
        return (s == 4'd15) ? s : s + 4'd1;
    endfunction

    // Expected effect of one judged (or timed-out) question, queued for the monitor.
    task automatic model_judge(input logic [1:0] b, input logic v);
        if (b == 2'b01) begin
            if (v) m_s1 = sat(m_s1); else m_s2 = sat(m_s2);
        end else if (b == 2'b10) begin
            if (v) m_s2 = sat(m_s2); else m_s1 = sat(m_s1);
        end
        sb_q.push_back(show_t'{b, v, m_s1, m_s2});
    endtask

    // Entry to the verdict display: q_valid falls outside of reset.
    always @(negedge clk) begin
        if (!reset && prev_qv && !q_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL show_unexpected: got verdict entry at %0t expected none", $time);
            end else begin
                show_t e;
                e = sb_q.pop_front();
                check("show_buzzed",   32'(buzzed),   32'(e.buzzed));
                check("show_verdict",  32'(verdict),  32'(e.verdict));
                check("show_score_p1", 32'(score_p1), 32'(e.s1));
                check("show_score_p2", 32'(score_p2), 32'(e.s2));
            end
        end
        prev_qv = q_valid;
    end

    task automatic do_start();
        int n;
        n = 0;
        start = 1'b1;
        tick();
        while (!q_load && n < BUDGET) begin
            tick();
            n++;
        end
        start = 1'b0;
        check("start_q_load",    32'(q_load),    32'd1);
        check("start_q_index",   32'(q_index),   32'd0);
        check("start_scores",    32'({score_p1, score_p2}), 32'd0);
        check("start_game_over", 32'(game_over), 32'd0);
        m_s1 = 4'd0;
        m_s2 = 4'd0;
        m_q  = 0;
    endtask

    // Waits for the next q_load or game_over and checks the round's timing and outcome.
    task automatic finish_round(input int exp_n, input string tag);
        int         n;
        logic       done_exp;
        logic [1:0] w_exp;
        n = 0;
        while (!q_load && !game_over && n < BUDGET) begin
            tick();
            n++;
        end
        check({tag, "_cycles"}, 32'(n), 32'(exp_n));
        done_exp = (m_s1 >= 4'(WIN_SCORE)) || (m_s2 >= 4'(WIN_SCORE)) || (m_q == NUM_Q - 1);
        check({tag, "_game_over"}, 32'(game_over), 32'(done_exp));
        if (done_exp) begin
            w_exp = (m_s1 > m_s2) ? 2'b01 : (m_s2 > m_s1) ? 2'b10 : 2'b00;
            check({tag, "_winner"}, 32'(winner), 32'(w_exp));
        end else begin
            m_q++;
        end
        check({tag, "_q_index"}, 32'(q_index), 32'(m_q));
    endtask

    task automatic run_round(input round_t r, input int idx);
        string tag;
        tag = $sformatf("r%0d", idx);
        if (r.start_game) do_start();
        if (!r.hold) begin
            p1_req = 1'b0;
            p2_req = 1'b0;
        end
        tick();
        if (r.p1 || r.p2) begin
            repeat (r.dly) tick();
            p1_ans = r.p1a;
            p2_ans = r.p2a;
            q_ans  = r.qa;
            if (r.p1) p1_req = 1'b1;
            if (r.p2) p2_req = 1'b1;
            model_judge(r.exp_buzzed, r.exp_verdict);
            finish_round(2 + SHOW_CYC, tag);
        end else begin
            model_judge(r.exp_buzzed, r.exp_verdict);
            finish_round(TIMEOUT_CYC + SHOW_CYC, tag);
        end
    endtask

    initial begin
        // start, hold, p1, p2, p1a, p2a, qa, dly, buzzed, verdict
        // game A continues after the hand-written first question
        tbl.push_back(round_t'{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 2'b01, 1'b0});
        tbl.push_back(round_t'{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2, 2'b10, 1'b1});
        tbl.push_back(round_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2'b00, 1'b0});
        tbl.push_back(round_t'{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, TIMEOUT_CYC - 1, 2'b10, 1'b1});
        tbl.push_back(round_t'{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3, 2'b01, 1'b0});
        tbl.push_back(round_t'{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1, 2'b10, 1'b1});
        // game B: P2 keeps answering wrong, one round with P2 held high
        tbl.push_back(round_t'{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 2'b10, 1'b0});
        tbl.push_back(round_t'{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5, 2'b10, 1'b0});
        tbl.push_back(round_t'{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 2'b10, 1'b0});
        tbl.push_back(round_t'{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2'b00, 1'b0});
        tbl.push_back(round_t'{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4, 2'b10, 1'b0});
        tbl.push_back(round_t'{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 2'b10, 1'b0});
        // game C: every question times out
        for (int i = 0; i < NUM_Q; i++) begin
            tbl.push_back(round_t'{(i == 0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2'b00, 1'b0});
        end
        // game D: P2 correct twice before the reset sequence
        tbl.push_back(round_t'{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 2'b10, 1'b1});
        tbl.push_back(round_t'{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 2'b10, 1'b1});

        reset  = 1'b1;
        start  = 1'b0;
        p1_req = 1'b0;
        p2_req = 1'b0;
        p1_ans = 1'b0;
        p2_ans = 1'b0;
        q_ans  = 1'b0;
        tick();
        tick();
        check("reset_outputs", 32'({q_index, q_load, q_valid, score_p1, score_p2,
                                    buzzed, verdict, game_over, winner}), 32'd0);
        reset = 1'b0;
        tick();

        // First question: P1 buzzes correctly, latency and next-question load.
        do_start();
        tick();
        p1_ans = 1'b1;
        q_ans  = 1'b1;
        p1_req = 1'b1;
        model_judge(2'b01, 1'b1);
        tick();
        check("q0_judge_buzzed",   32'(buzzed),   32'h1);
        check("q0_judge_q_valid",  32'(q_valid),  32'h1);
        check("q0_judge_score_p1", 32'(score_p1), 32'h0);
        tick();
        check("q0_show_score_p1",  32'(score_p1), 32'h1);
        check("q0_show_verdict",   32'(verdict),  32'h1);
        check("q0_show_q_valid",   32'(q_valid),  32'h0);
        repeat (SHOW_CYC - 1) tick();
        check("q0_show_hold_q_load", 32'(q_load), 32'h0);
        check("q0_show_hold_buzzed", 32'(buzzed), 32'h1);
        tick();
        check("q0_next_q_load",  32'(q_load),  32'h1);
        check("q0_next_q_index", 32'(q_index), 32'h1);
        m_q = 1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_round(tbl[i], i + 1);
        end

        // Game D third question, then reset in the middle of the verdict display.
        p1_req = 1'b0;
        p2_req = 1'b0;
        tick();
        p2_ans = 1'b1;
        q_ans  = 1'b1;
        p2_req = 1'b1;
        model_judge(2'b10, 1'b1);
        tick();
        tick();
        tick();
        check("rst_pre_score_p2", 32'(score_p2), 32'd3);
        check("rst_pre_q_valid",  32'(q_valid),  32'd0);
        reset = 1'b1;
        tick();
        check("rst_outputs", 32'({q_index, q_load, q_valid, score_p1, score_p2,
                                  buzzed, verdict, game_over, winner}), 32'd0);
        reset = 1'b0;
        repeat (3) tick();
        check("rst_idle_q_load",  32'(q_load),  32'd0);
        check("rst_idle_q_valid", 32'(q_valid), 32'd0);
        do_start();
        tick();
        repeat (5) tick();
        check("held_buzzed",  32'(buzzed),  32'd0);
        check("held_q_valid", 32'(q_valid), 32'd1);
        model_judge(2'b00, 1'b0);
        finish_round(TIMEOUT_CYC + SHOW_CYC - 5, "held");

        tick();
        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_Q, default 8: questions per game, range 1..8.
REQ-002 The block SHALL have parameter WIN_SCORE, default 5: score that ends the game early, range 1..15.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 1000: cycles allowed for a buzz before the question is skipped, minimum 2.
REQ-004 The block SHALL have parameter SHOW_CYC, default 100: cycles the verdict is held before the next question, minimum 1.
REQ-005 The block SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1: level; sampled only in IDLE and DONE.
REQ-008 The block SHALL have ports p1_req and p2_req, input, 1 each: player buzzer levels; only the rising edge counts.
REQ-009 The block SHALL have ports p1_ans and p2_ans, input, 1 each: player answer ("equal" = 1), sampled in the same cycle as the winning edge.
REQ-010 The block SHALL have port q_ans, input, 1: correct answer from the question generator, valid whenever q_valid is high.
REQ-011 The block SHALL have port q_index, output, 3: current question number, driving the question generator's state input.
REQ-012 The block SHALL have port q_load, output, 1: one-cycle pulse asking the generator to present question q_index.
REQ-013 The block SHALL have port q_valid, output, 1: high in WAIT and JUDGE.
REQ-014 The block SHALL have ports score_p1 and score_p2, output, 4 each: running scores.
REQ-015 The block SHALL have port buzzed, output, 2: 00 none, 01 P1, 10 P2; held through SHOW.
REQ-016 The block SHALL have port verdict, output, 1: 1 = the buzzing player was correct; meaningful only in SHOW.
REQ-017 The block SHALL have port game_over, output, 1: high in DONE.
REQ-018 The block SHALL have port winner, output, 2: 00 tie, 01 P1, 10 P2; valid only while game_over is high.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, WAIT, JUDGE, SHOW, DONE.
REQ-020 IDLE -> LOAD on start=1; the scores and q_index SHALL be cleared on this transition.
REQ-021 LOAD SHALL last exactly 1 cycle, assert q_load, clear buzzed and the timeout counter, and go to WAIT.
REQ-022 Edge detectors SHALL register p1_req and p2_req every cycle; an edge is req=1 while the previous sample was 0; edges outside WAIT are discarded.
REQ-023 In WAIT, the first edge SHALL latch buzzed and the sampled answer and move to JUDGE the next cycle.
REQ-024 Simultaneous P1 and P2 edges SHALL be resolved by a round-robin priority bit: reset value favours P1, and the bit toggles after every tie it resolves.
REQ-025 If no edge arrives within TIMEOUT_CYC cycles of entering WAIT, the FSM SHALL go to SHOW with buzzed=00, verdict=0 and no score change.
REQ-026 An edge arriving in the same cycle the timeout expires SHALL take precedence over the timeout.
REQ-027 JUDGE SHALL last 1 cycle: verdict = (latched answer == q_ans); if correct, the buzzer's score increments, otherwise the opponent's score increments.
REQ-028 Scores SHALL saturate at 15.
REQ-029 SHOW SHALL hold for SHOW_CYC cycles, then go to DONE if either score >= WIN_SCORE or q_index == NUM_Q-1; otherwise it increments q_index and goes to LOAD.
REQ-030 DONE SHALL hold the scores and set winner by comparing them; start=1 in DONE goes to LOAD with the scores and q_index cleared.
REQ-031 Latency SHALL be: edge in WAIT cycle N -> JUDGE at N+1 -> score visible at N+2 -> SHOW from N+2.

Reset
REQ-032 On reset=1 at a clock edge, from any state including mid-round, the FSM SHALL enter IDLE.
REQ-033 Reset SHALL drive all of the following to zero: q_index, q_load, q_valid, score_p1, score_p2, buzzed, verdict, game_over, winner, both counters and the edge-detector history.
REQ-034 Reset SHALL set the priority bit to favour P1.

Verification
REQ-035 The bench SHALL cover: start, then P1 edge with p1_ans=1 and q_ans=1 -> buzzed=01, verdict=1, score_p1=1 two cycles after the edge, then a q_load pulse after SHOW_CYC cycles with q_index=1.
REQ-036 The bench SHALL cover: P1 and P2 edges in the same cycle on two consecutive questions -> buzzed=01 on the first and buzzed=10 on the second.
REQ-037 The bench SHALL cover: no buzz for TIMEOUT_CYC cycles -> SHOW with buzzed=00 and scores unchanged; plus an edge in the exact expiry cycle -> the buzz is judged.
REQ-038 The bench SHALL cover: P2 answers wrong five times with WIN_SCORE=5 -> score_p1=5, game_over=1, winner=01; P2 held at 1 produces no further edges.
REQ-039 The bench SHALL cover: NUM_Q=8 with all timeouts -> DONE after question 7, winner=00; then start -> scores=0 and q_index=0.
REQ-040 The bench SHALL cover: reset asserted during SHOW with score_p2=3 -> next cycle IDLE, all outputs 0, and a held buzzer does not register as an edge.
